eth_header_inserter: RTL
========================

# eth_header_inserter

Parametrised Ethernet framing stage between the AES engine's output stream and the TSE MAC transmit interface. Prepends a programmable 128-bit MAC header (16-bit pad, destination MAC, source MAC, EtherType) to every payload packet on an Avalon-ST stream of configurable width. Exposes an Avalon-MM register slave for the header fields, enable and statistics. Adds what the fixed 32-bit, fixed-EtherType scheme lacks: runtime EtherType, bypass mode, packet/drop counters, and stream widths above 32.

## Interface
- STREAM_WIDTH, 32, data bus width; one of 32, 64, 128
- BASE_ADDR, 'h1000, peripheral base address
- ADDRESS_SIZE, 32, Avalon-MM address width
- REG_SIZE, 32, Avalon-MM data width
- COUNT_WIDTH, 32, width of the statistics counters
- EMPTY_WIDTH, $clog2(STREAM_WIDTH/8) (minimum 1), derived
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- avs_address  in  ADDRESS_SIZE  byte address
- avs_write / avs_read  in  1  MM strobes
- avs_writedata  in  REG_SIZE  write data
- avs_readdata  out  REG_SIZE  read data, registered
- avs_readdatavalid  out  1  pulse, one cycle after avs_read
- snk_data  in  STREAM_WIDTH, plus snk_valid, snk_sop, snk_eop (1 bit each), snk_empty (EMPTY_WIDTH): payload input
- snk_ready  out  1
- src_data  out  STREAM_WIDTH, plus src_valid, src_sop, src_eop (1 bit each), src_empty (EMPTY_WIDTH): framed output
- src_ready  in  1

## Operation
- Registers are at BASE_ADDR + offset. Any other address reads 0 and ignores writes.
  - 0x00 SRC_MAC_HI [15:0]: source MAC bits [47:32]
  - 0x04 SRC_MAC_LO: source MAC bits [31:0]
  - 0x08 DST_MAC_HI / 0x0C DST_MAC_LO: destination MAC, same split as the source
  - 0x10 ETH_TYPE [15:0]: reset 16'h0800
  - 0x14 CTRL: bit0 enable, reset 1
  - 0x18 PKT_COUNT: read-only value; any write clears it
  - 0x1C DROP_COUNT: read-only value; any write clears it
  - All MAC registers reset to 0. Unused read bits return 0.
- Header word H[127:0] = {16'h0, dst[47:0], src[47:0], eth_type}.
  - Sent MSB-first in HDR_BEATS = 128/STREAM_WIDTH beats.
  - Beat k carries H[127-k*STREAM_WIDTH -: STREAM_WIDTH].
- FSM states: IDLE, HEADER, PAYLOAD, BYPASS.
  - **IDLE**
    - snk_ready = 1 only when the current beat lacks sop. Such a beat is discarded and DROP_COUNT is incremented.
    - A beat with sop, when enable = 1: latch dst, src and eth_type into a snapshot, clear the beat counter, go to HEADER. The sop beat is not consumed.
    - A beat with sop, when enable = 0: go to BYPASS. The beat is not consumed.
  - **HEADER**
    - snk_ready = 0; src_valid = 1; src_data = snapshot beat[cnt].
    - src_sop = (cnt == 0); src_eop = 0; src_empty = 0.
    - Each src_ready increments cnt. Acceptance of the last beat goes to PAYLOAD.
  - **PAYLOAD**
    - Combinational pass-through: src_valid = snk_valid, snk_ready = src_ready; data, eop and empty are forwarded.
    - src_sop is forced to 0.
    - An accepted beat with eop increments PKT_COUNT and returns to IDLE.
  - **BYPASS**
    - Same as PAYLOAD, except sop is also forwarded unmodified.
    - eop increments PKT_COUNT and returns to IDLE.
- Mid-packet register writes affect only the next packet, because the header comes from the snapshot and enable is sampled only in IDLE.
- A sop arriving in PAYLOAD or BYPASS is forwarded as data (with sop cleared in PAYLOAD). It is not treated specially.
- Counters saturate at all-ones.
  - A clear and an increment in the same cycle: the clear wins and the result is 0.

## Timing
- Reset values: all outputs 0 (src_valid = 0, snk_ready = 0, avs_readdatavalid = 0); FSM in IDLE; registers at their reset values.
- Reset asserted mid-packet aborts the packet immediately. There is no eop on src; the next packet starts clean.
- Header latency: the first header beat is valid on the cycle after sop is first seen in IDLE. Back-to-back header beats flow at one per cycle while src_ready = 1.
- Payload latency: 0 cycles (combinational). Overhead per packet: HDR_BEATS + 1 cycles.
- src_valid and src_data stay stable while src_ready = 0 (Avalon-ST, ready latency 0).
- MM reads: fixed read latency of 1. Writes take effect on the next cycle. Read and write in the same cycle: the read returns the old value.

## Structure
- The register offsets, ETH_TYPE default and header layout constants (MAC_HEADER_WIDTH, MAC_ADDR_PAD) live in the shared AES top package. Add CTRL_ADDR, PKT_COUNT_ADDR and DROP_COUNT_ADDR there.
- Add an FSM state enum typedef to the package.
- One sub-module, eth_hdr_regs, holds the Avalon-MM decode, the registers and the saturating counters. It takes inc_pkt and inc_drop pulses as inputs.

## Test plan
- **Register reset:** after reset, read 0x1010 -> 0x0800; read 0x1014 -> 1.
- **Header insertion, STREAM_WIDTH = 32:**
  - Setup: src = 0x0011_2233_4455, dst = 0xAABB_CCDD_EEFF, 3-beat payload 0x1, 0x2, 0x3 with eop and empty = 2.
  - Expected src beats: 0x0000AABB (sop), 0xCCDDEEFF, 0x00112233, 0x44550800, 0x1, 0x2, 0x3 (eop, empty = 2).
  - PKT_COUNT = 1.
- **Backpressure:** random src_ready at 50% with STREAM_WIDTH = 64 -> the same header delivered as 2 beats, no data loss, data held stable while stalled.
- **Bypass:** write CTRL = 0, send a 2-beat packet -> output identical to input; PKT_COUNT increments.
- **Snapshot and drop:**
  - Write ETH_TYPE = 0x86DD during PAYLOAD -> the current header is unchanged; the next header ends in 0x86DD.
  - A non-sop beat in IDLE -> DROP_COUNT = 1, nothing appears on src.
- **Reset mid-HEADER:** assert rst after beat 1 -> src_valid = 0 on the next cycle; a following packet is framed correctly.

Source files
------------

// File: rtl/eth_header_inserter_pkg.sv
// Shared constants and types for the Ethernet framing stage: register map,
// MAC header layout and the framer state encoding.
package eth_header_inserter_pkg;

  // Header layout: {pad, destination MAC, source MAC, EtherType}
  localparam int MAC_HEADER_WIDTH = 128;
  localparam int MAC_ADDR_PAD     = 16;
  localparam int MAC_ADDR_WIDTH   = 48;
  localparam int ETH_TYPE_WIDTH   = 16;

  localparam logic [ETH_TYPE_WIDTH-1:0] ETH_TYPE_DEFAULT = 16'h0800;

  // Byte offsets of the registers relative to the peripheral base address
  localparam logic [7:0] SRC_MAC_HI_ADDR = 8'h00;
  localparam logic [7:0] SRC_MAC_LO_ADDR = 8'h04;
  localparam logic [7:0] DST_MAC_HI_ADDR = 8'h08;
  localparam logic [7:0] DST_MAC_LO_ADDR = 8'h0C;
  localparam logic [7:0] ETH_TYPE_ADDR   = 8'h10;
  localparam logic [7:0] CTRL_ADDR       = 8'h14;
  localparam logic [7:0] PKT_COUNT_ADDR  = 8'h18;
  localparam logic [7:0] DROP_COUNT_ADDR = 8'h1C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_BYPASS  = 2'd3
  } eth_state_e;

endpackage

// File: rtl/eth_hdr_regs.sv
// Avalon-MM register block for the header inserter: MAC/EtherType fields,
// enable bit and the saturating packet/drop statistics counters.
module eth_hdr_regs
  import eth_header_inserter_pkg::*;
#(
  parameter int BASE_ADDR    = 'h1000,
  parameter int ADDRESS_SIZE = 32,
  parameter int REG_SIZE     = 32,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_SIZE-1:0] avs_address,
  input  logic                    avs_write,
  input  logic                    avs_read,
  input  logic [REG_SIZE-1:0]     avs_writedata,
  output logic [REG_SIZE-1:0]     avs_readdata,
  output logic                    avs_readdatavalid,
  input  logic                    inc_pkt,
  input  logic                    inc_drop,
  output logic [47:0]             src_mac,
  output logic [47:0]             dst_mac,
  output logic [15:0]             eth_type,
  output logic                    enable
);

  logic [ADDRESS_SIZE-1:0] offset;
  logic                    in_window;
  logic [7:0]              reg_off;
  logic [31:0]             wdata;
  logic                    clr_pkt;
  logic                    clr_drop;
  logic [REG_SIZE-1:0]     rd_value;
  logic [COUNT_WIDTH-1:0]  pkt_count;
  logic [COUNT_WIDTH-1:0]  drop_count;

  // Counter update: a clear beats a simultaneous increment, and the count sticks at all-ones
  function automatic logic [COUNT_WIDTH-1:0] sat_next(input logic [COUNT_WIDTH-1:0] cur,
                                                      input logic inc,
                                                      input logic clr);
    if (clr) return '0;
    if (inc && (cur != '1)) return cur + COUNT_WIDTH'(1);
    return cur;
  endfunction

  // Address decode: only the low 256 bytes above the base can hold a register
  always_comb begin
    offset    = avs_address - ADDRESS_SIZE'(BASE_ADDR);
    in_window = (offset[ADDRESS_SIZE-1:8] == '0);
    reg_off   = offset[7:0];
    wdata     = avs_writedata[31:0];
    clr_pkt   = avs_write && in_window && (reg_off == PKT_COUNT_ADDR);
    clr_drop  = avs_write && in_window && (reg_off == DROP_COUNT_ADDR);
  end

  // Writable configuration registers; unknown offsets are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      src_mac  <= '0;
      dst_mac  <= '0;
      eth_type <= ETH_TYPE_DEFAULT;
      enable   <= 1'b1;
    end else if (avs_write && in_window) begin
      case (reg_off)
        SRC_MAC_HI_ADDR: src_mac[47:32] <= wdata[15:0];
        SRC_MAC_LO_ADDR: src_mac[31:0]  <= wdata;
        DST_MAC_HI_ADDR: dst_mac[47:32] <= wdata[15:0];
        DST_MAC_LO_ADDR: dst_mac[31:0]  <= wdata;
        ETH_TYPE_ADDR:   eth_type       <= wdata[15:0];
        CTRL_ADDR:       enable         <= wdata[0];
        default: ;
      endcase
    end
  end

  // Statistics counters, cleared by any write to their offset
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      pkt_count  <= sat_next(pkt_count, inc_pkt, clr_pkt);
      drop_count <= sat_next(drop_count, inc_drop, clr_drop);
    end
  end

  // Read mux; anything outside the register map reads as zero
  always_comb begin
    rd_value = '0;
    if (in_window) begin
      case (reg_off)
        SRC_MAC_HI_ADDR: rd_value = REG_SIZE'(src_mac[47:32]);
        SRC_MAC_LO_ADDR: rd_value = REG_SIZE'(src_mac[31:0]);
        DST_MAC_HI_ADDR: rd_value = REG_SIZE'(dst_mac[47:32]);
        DST_MAC_LO_ADDR: rd_value = REG_SIZE'(dst_mac[31:0]);
        ETH_TYPE_ADDR:   rd_value = REG_SIZE'(eth_type);
        CTRL_ADDR:       rd_value = REG_SIZE'(enable);
        PKT_COUNT_ADDR:  rd_value = REG_SIZE'(pkt_count);
        DROP_COUNT_ADDR: rd_value = REG_SIZE'(drop_count);
        default:         rd_value = '0;
      endcase
    end
  end

  // Registered read port with a fixed latency of one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_value;
    end
  end

endmodule

// File: rtl/eth_header_inserter.sv
// Prepends a programmable 128-bit MAC header to each Avalon-ST payload packet,
// or passes packets through untouched when the enable bit is clear.
module eth_header_inserter
  import eth_header_inserter_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int BASE_ADDR    = 'h1000,
  parameter int ADDRESS_SIZE = 32,
  parameter int REG_SIZE     = 32,
  parameter int COUNT_WIDTH  = 32,
  parameter int EMPTY_WIDTH  = (STREAM_WIDTH / 8 > 1) ? $clog2(STREAM_WIDTH / 8) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_SIZE-1:0] avs_address,
  input  logic                    avs_write,
  input  logic                    avs_read,
  input  logic [REG_SIZE-1:0]     avs_writedata,
  output logic [REG_SIZE-1:0]     avs_readdata,
  output logic                    avs_readdatavalid,
  input  logic [STREAM_WIDTH-1:0] snk_data,
  input  logic                    snk_valid,
  input  logic                    snk_sop,
  input  logic                    snk_eop,
  input  logic [EMPTY_WIDTH-1:0]  snk_empty,
  output logic                    snk_ready,
  output logic [STREAM_WIDTH-1:0] src_data,
  output logic                    src_valid,
  output logic                    src_sop,
  output logic                    src_eop,
  output logic [EMPTY_WIDTH-1:0]  src_empty,
  input  logic                    src_ready
);

  localparam int HDR_BEATS = MAC_HEADER_WIDTH / STREAM_WIDTH;
  localparam int CNT_WIDTH = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(HDR_BEATS - 1);

  eth_state_e state;
  logic [CNT_WIDTH-1:0] hdr_cnt;
  logic [0:HDR_BEATS-1][STREAM_WIDTH-1:0] hdr_snap;

  logic [47:0] src_mac;
  logic [47:0] dst_mac;
  logic [15:0] eth_type;
  logic        enable;
  logic        inc_pkt;
  logic        inc_drop;
  logic        eop_fire;

  eth_hdr_regs #(
    .BASE_ADDR   (BASE_ADDR),
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .REG_SIZE    (REG_SIZE),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_regs (
    .clk              (clk),
    .rst              (rst),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_read         (avs_read),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .inc_pkt          (inc_pkt),
    .inc_drop         (inc_drop),
    .src_mac          (src_mac),
    .dst_mac          (dst_mac),
    .eth_type         (eth_type),
    .enable           (enable)
  );

  assign eop_fire = snk_valid && src_ready && snk_eop;

  // Stream outputs per state; everything is held low while reset is asserted
  always_comb begin
    snk_ready = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
    src_empty = '0;
    inc_pkt   = 1'b0;
    inc_drop  = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          snk_ready = !(snk_valid && snk_sop);
          inc_drop  = snk_valid && !snk_sop;
        end
        ST_HEADER: begin
          src_valid = 1'b1;
          src_data  = hdr_snap[hdr_cnt];
          src_sop   = (hdr_cnt == '0);
        end
        ST_PAYLOAD: begin
          src_valid = snk_valid;
          snk_ready = src_ready;
          src_data  = snk_data;
          src_eop   = snk_eop;
          src_empty = snk_empty;
          inc_pkt   = eop_fire;
        end
        ST_BYPASS: begin
          src_valid = snk_valid;
          snk_ready = src_ready;
          src_data  = snk_data;
          src_sop   = snk_sop;
          src_eop   = snk_eop;
          src_empty = snk_empty;
          inc_pkt   = eop_fire;
        end
        default: ;
      endcase
    end
  end

  // Framer FSM: snapshot the header at sop, emit it beat by beat, then forward the payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr_cnt  <= '0;
      hdr_snap <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (snk_valid && snk_sop) begin
            if (enable) begin
              hdr_snap <= {{MAC_ADDR_PAD{1'b0}}, dst_mac, src_mac, eth_type};
              hdr_cnt  <= '0;
              state    <= ST_HEADER;
            end else begin
              state <= ST_BYPASS;
            end
          end
        end
        ST_HEADER: begin
          if (src_ready) begin
            if (hdr_cnt == LAST_BEAT) state <= ST_PAYLOAD;
            else hdr_cnt <= hdr_cnt + CNT_WIDTH'(1);
          end
        end
        ST_PAYLOAD, ST_BYPASS: begin
          if (eop_fire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
